// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, req/ack instruction memory port, valid/ready decoder port.
// Optional macro FETCH_STALL_CNT_EN adds a saturating stall_cnt output.
module fetch_unit #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
  parameter int unsigned            PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  pc_src,
  input  logic [ADDR_WIDTH-1:0] imm_op,
`ifdef FETCH_STALL_CNT_EN
  output logic                  misalign_err,
  output logic [31:0]           stall_cnt
`else
  output logic                  misalign_err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [DATA_WIDTH-1:0]   r_instr;
  logic [ADDR_WIDTH-1:0]   r_instr_pc;
  logic                    r_misalign;
  logic [ADDR_WIDTH-1:0]   w_target;
  logic [ADDR_WIDTH-1:0]   w_seq;
  logic                    w_accept;
  logic                    w_capture;

  assign w_target  = r_instr_pc + imm_op;
  assign w_seq     = r_instr_pc + ADDR_WIDTH'(PC_STEP);
  assign w_accept  = (r_state == ISSUE) && instr_ready;
  assign w_capture = (r_state == FETCH) && mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    mem_req      = 1'b0;
    instr_valid  = 1'b0;
    case (r_state)
      IDLE:  w_state_next = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) w_state_next = ISSUE;
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (instr_ready) w_state_next = FETCH;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      if (w_capture) begin
        r_instr    <= mem_rdata;
        r_instr_pc <= r_pc;
      end
      if (w_accept) begin
        // Branch targets are word-aligned by dropping the low bits; the fault is remembered.
        if (pc_src) begin
          r_pc <= {w_target[ADDR_WIDTH-1:2], 2'b00};
          if (w_target[1:0] != 2'b00) r_misalign <= 1'b1;
        end else begin
          r_pc <= w_seq;
        end
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = ((r_state == FETCH) && !mem_ack) || ((r_state == ISSUE) && !instr_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_stall_cnt <= '0;
    else if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign mem_addr     = r_pc;
  assign instr        = r_instr;
  assign instr_pc     = r_instr_pc;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; honours FETCH_STALL_CNT_EN when defined.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_src;
  logic [31:0] imm_op;
  logic        misalign_err;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0),
    .PC_STEP    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc_src       (pc_src),
    .imm_op       (imm_op),
`ifdef FETCH_STALL_CNT_EN
    .misalign_err (misalign_err),
    .stall_cnt    (stall_cnt)
`else
    .misalign_err (misalign_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects FETCH at addr; holds ack low for `waits` cycles, then acks with word.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, input int unsigned waits);
    for (int unsigned i = 0; i < waits; i++) begin
      check("req_hold", 32'(mem_req), 32'd1);
      check("addr_hold", mem_addr, addr);
      step();
    end
    check("req", 32'(mem_req), 32'd1);
    check("addr", mem_addr, addr);
    check("valid_in_fetch", 32'(instr_valid), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = word;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    check("valid", 32'(instr_valid), 32'd1);
    check("instr", instr, word);
    check("instr_pc", instr_pc, addr);
    check("req_off", 32'(mem_req), 32'd0);
  endtask

  // Holds ready low for `hold` cycles in ISSUE, then accepts with the given branch decision.
  task automatic do_accept(input logic src, input logic [31:0] imm, input int unsigned hold,
                           input logic [31:0] word, input logic [31:0] pc);
    instr_ready = 1'b0;
    for (int unsigned i = 0; i < hold; i++) begin
      step();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_instr", instr, word);
      check("stall_pc", instr_pc, pc);
      check("stall_noreq", 32'(mem_req), 32'd0);
    end
    instr_ready = 1'b1;
    pc_src      = src;
    imm_op      = imm;
    step();
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    imm_op      = '0;
    check("acc_valid_drop", 32'(instr_valid), 32'd0);
    check("acc_req", 32'(mem_req), 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    imm_op      = '0;
    repeat (2) step();

    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_mis", 32'(misalign_err), 32'd0);
    rst_n = 1'b1;
    step();

    // Sequential zero-wait fetches
    do_fetch(32'h0, 32'h0010_0093, 0);
    do_accept(1'b0, '0, 0, 32'h0010_0093, 32'h0);
    do_fetch(32'h4, 32'h0020_8113, 0);
    do_accept(1'b0, '0, 0, 32'h0020_8113, 32'h4);
    do_fetch(32'h8, 32'h0030_0193, 0);
    do_accept(1'b0, '0, 0, 32'h0030_0193, 32'h8);

    // Delayed ack, then a stalled decoder
    do_fetch(32'hC, 32'h0040_0213, 3);
`ifdef FETCH_STALL_CNT_EN
    check("stall_cnt_mem", stall_cnt, 32'd3);
`endif
    do_accept(1'b0, '0, 4, 32'h0040_0213, 32'hC);
`ifdef FETCH_STALL_CNT_EN
    check("stall_cnt_dec", stall_cnt, 32'd7);
`endif

    // Backward taken branch from 0x10, forward branch back, then not-taken
    do_fetch(32'h10, 32'hFE20_9CE3, 0);
    do_accept(1'b1, 32'hFFFF_FFF8, 0, 32'hFE20_9CE3, 32'h10);
    do_fetch(32'h8, 32'h0020_9463, 0);
    do_accept(1'b1, 32'h0000_0008, 0, 32'h0020_9463, 32'h8);
    do_fetch(32'h10, 32'hFE20_9CE3, 0);
    do_accept(1'b0, 32'hFFFF_FFF8, 0, 32'hFE20_9CE3, 32'h10);
    check("mis_clean", 32'(misalign_err), 32'd0);

    // Misaligned target from 0x0 and stickiness
    do_fetch(32'h14, 32'hFE00_06E3, 0);
    do_accept(1'b1, 32'hFFFF_FFEC, 0, 32'hFE00_06E3, 32'h14);
    check("mis_aligned_br", 32'(misalign_err), 32'd0);
    do_fetch(32'h0, 32'h0000_0363, 0);
    do_accept(1'b1, 32'h0000_0006, 0, 32'h0000_0363, 32'h0);
    check("mis_set", 32'(misalign_err), 32'd1);
    do_fetch(32'h4, 32'hFE00_0EE3, 0);
    do_accept(1'b1, 32'hFFFF_FFFC, 0, 32'hFE00_0EE3, 32'h4);
    check("mis_sticky", 32'(misalign_err), 32'd1);

    // Address wrap in both directions
    do_fetch(32'h0, 32'hFE00_0EE3, 0);
    do_accept(1'b1, 32'hFFFF_FFFC, 0, 32'hFE00_0EE3, 32'h0);
    do_fetch(32'hFFFF_FFFC, 32'h0000_0013, 0);
    do_accept(1'b0, '0, 0, 32'h0000_0013, 32'hFFFF_FFFC);
    do_fetch(32'h0, 32'h0000_0013, 0);
    do_accept(1'b0, '0, 0, 32'h0000_0013, 32'h0);
    check("mis_sticky2", 32'(misalign_err), 32'd1);

    // Asynchronous reset mid-FETCH with a late ack around it
    check("pre_rst_addr", mem_addr, 32'h4);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(mem_req), 32'd0);
    check("arst_addr", mem_addr, 32'h0);
    check("arst_mis", 32'(misalign_err), 32'd0);
    check("arst_instr", instr, 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    step();
    rst_n = 1'b1;
    step();
    mem_ack = 1'b0;
    check("post_rst_req", 32'(mem_req), 32'd1);
    check("post_rst_valid", 32'(instr_valid), 32'd0);
    check("post_rst_instr", instr, 32'h0);
`ifdef FETCH_STALL_CNT_EN
    check("post_rst_stall", stall_cnt, 32'd0);
`endif
    do_fetch(32'h0, 32'h0010_0093, 1);
    do_accept(1'b0, '0, 0, 32'h0010_0093, 32'h0);
    check("post_rst_next", mem_addr, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
